mem_access_unit: RTL and testbench

Initiator-side controller driving the word-wide, big-endian data RAM on behalf of the CPU MEM stage. Accepts byte/halfword/word load and store requests, and drives the RAM ce/we/addr/wtData. Sub-word loads are done by extract plus sign/zero extend. Sub-word stores are done by read-modify-write. Misaligned and out-of-range accesses are flagged instead of issued.

---
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-wide, big-endian data RAM.
// Byte/half/word loads are extracted and sign/zero extended. Sub-word stores
// use read-modify-write. Misaligned or reserved-size requests complete with
// an error and no RAM access.
// Optional feature macro: MEM_ACC_RANGE_CHECK_EN. When defined, any address
// >= RAM_BYTES is rejected with an error.
module mem_access_unit #(
   parameter int ADDR_W    = 32,
   parameter int RAM_BYTES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

`ifdef MEM_ACC_RANGE_CHECK_EN
   localparam logic RANGE_EN = 1'b1;
`else
   localparam logic RANGE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Request fields latched at acceptance.
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_signed;
   logic [1:0]  lat_off;
   logic [15:0] lat_wdata;

   logic        accept;
   logic        size_err;
   logic        range_err;
   logic        req_err;

   // Pick the big-endian lane out of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] off, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Overlay the new byte/half lane onto the word read back from RAM.
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                         input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      if (size == 2'b00) begin
         case (off)
            2'd0:    r[31:24] = d[7:0];
            2'd1:    r[23:16] = d[7:0];
            2'd2:    r[15:8]  = d[7:0];
            default: r[7:0]   = d[7:0];
         endcase
      end else begin
         if (off[1]) begin
            r[15:0] = d;
         end else begin
            r[31:16] = d;
         end
      end
      return r;
   endfunction

   assign accept    = req_valid & (state == IDLE);
   assign size_err  = (req_size == 2'b11) |
                      ((req_size == 2'b01) & req_addr[0]) |
                      ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
   assign range_err = RANGE_EN & (req_addr >= ADDR_W'(RAM_BYTES));
   assign req_err   = size_err | range_err;

   // Next-state decode for the access sequencer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_nxt = RESP;
               end else if (req_we && (req_size == 2'b10)) begin
                  state_nxt = WR;
               end else begin
                  state_nxt = RD;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RD: begin
            if (lat_we) begin
               state_nxt = WR;
            end else begin
               state_nxt = RESP;
            end
         end
         WR:      state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and registered control outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         ram_ce     <= 1'b0;
         ram_we     <= 1'b0;
      end else begin
         state      <= state_nxt;
         req_ready  <= (state_nxt == IDLE);
         resp_valid <= (state_nxt == RESP);
         resp_err   <= accept & req_err;
         ram_ce     <= (state_nxt == RD) || (state_nxt == WR);
         ram_we     <= (state_nxt == WR);
      end
   end

   // Request latching, RAM address/data and load-result datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we     <= 1'b0;
         lat_size   <= 2'b00;
         lat_signed <= 1'b0;
         lat_off    <= 2'b00;
         lat_wdata  <= 16'h0000;
         ram_addr   <= '0;
         ram_wdata  <= 32'h0000_0000;
         resp_rdata <= 32'h0000_0000;
      end else begin
         if (accept) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            if (!req_err) begin
               ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            if (req_we) begin
               ram_wdata <= req_wdata;
            end
            // Stores and errors report zero read data.
            if (req_err || req_we) begin
               resp_rdata <= 32'h0000_0000;
            end
         end else if (state == RD) begin
            if (lat_we) begin
               ram_wdata <= merge(ram_rdata, lat_wdata, lat_size, lat_off);
            end else begin
               resp_rdata <= extract(ram_rdata, lat_size, lat_off, lat_signed);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-wide RAM model.
module tb_mem_access_unit;
   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:255];

   int vectors;
   int miscompares;

   // Results of the last transaction.
   int          r_lat;
   logic        r_err;
   logic [31:0] r_rdata;
   int          r_ce;
   int          r_we;
   logic [31:0] r_wdata;
   logic [31:0] r_addr;
   int          r_first_we;

   mem_access_unit #(.ADDR_W(32), .RAM_BYTES(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .ram_ce     (ram_ce),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read, posedge-write big-endian word RAM.
   assign ram_rdata = mem[ram_addr[9:2]];
   always @(posedge clk) begin
      if (ram_ce && ram_we) mem[ram_addr[9:2]] <= ram_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and observe the response with a bounded cycle budget.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      bit got;
      @(negedge clk);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0; r_lat = 0; r_err = 1'b0; r_rdata = 32'hDEAD_BEEF;
      r_ce = 0; r_we = 0; r_wdata = 32'h0; r_addr = 32'hFFFF_FFFF; r_first_we = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         @(negedge clk);
         if (ram_ce) begin
            if (r_ce == 0) r_addr = ram_addr;
            r_ce++;
         end
         if (ram_we) begin
            if (r_we == 0) r_first_we = r_ce;
            r_we++;
            r_wdata = ram_wdata;
         end
         if (resp_valid) begin
            got = 1'b1; r_lat = i; r_err = resp_err; r_rdata = resp_rdata;
         end
      end
      if (!got) $display("FAIL timeout: got %h expected %h", 32'd0, 32'd1);
      if (!got) miscompares++;
      @(negedge clk);
      check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_ce_we", {30'd0, ram_ce, ram_we}, 32'd0);
      check("rst_addr", ram_addr, 32'd0);
      check("rst_wdata", ram_wdata, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;

      // Word store then word load.
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
      check("sw_lat", r_lat, 32'd2);
      check("sw_err", {31'd0, r_err}, 32'd0);
      check("sw_rdata", r_rdata, 32'd0);
      check("sw_ce", r_ce, 32'd1);
      check("sw_addr", r_addr, 32'h10);
      check("sw_mem", mem[4], 32'h1122_3344);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check("lw_lat", r_lat, 32'd2);
      check("lw_rdata", r_rdata, 32'h1122_3344);
      check("lw_we", r_we, 32'd0);

      // Big-endian byte loads.
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      check("lb13", r_rdata, 32'h0000_0044);
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      check("lbu11", r_rdata, 32'h0000_0022);
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_FFFF);
      do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
      check("lb10_s", r_rdata, 32'hFFFF_FF80);
      do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      check("lb10_u", r_rdata, 32'h0000_0080);

      // Half store by read-modify-write.
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD);
      do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234);
      check("sh_lat", r_lat, 32'd3);
      check("sh_ce", r_ce, 32'd2);
      check("sh_we", r_we, 32'd1);
      check("sh_rd_first", r_first_we, 32'd2);
      check("sh_wdata", r_wdata, 32'hAABB_1234);
      check("sh_mem", mem[8], 32'hAABB_1234);
      check("sh_rdata", r_rdata, 32'd0);
      do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
      check("lh20_s", r_rdata, 32'hFFFF_AABB);
      do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
      check("lh20_u", r_rdata, 32'h0000_AABB);
      do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
      check("lh22_s", r_rdata, 32'h0000_1234);
      do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_005A);
      check("sb_mem", mem[8], 32'hAA5A_1234);
      do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_00EE);
      check("sb3_mem", mem[8], 32'hAA5A_12EE);

      // Misaligned and reserved-size errors.
      do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
      check("mis_w_err", {31'd0, r_err}, 32'd1);
      check("mis_w_lat", r_lat, 32'd1);
      check("mis_w_ce", r_ce, 32'd0);
      check("mis_w_rdata", r_rdata, 32'd0);
      do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
      check("mis_h_err", {31'd0, r_err}, 32'd1);
      check("mis_h_ce", r_ce, 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h0);
      check("rsv_err", {31'd0, r_err}, 32'd1);
      check("rsv_mem", mem[8], 32'hAA5A_12EE);

      // Range boundary.
      do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
      check("top_err", {31'd0, r_err}, 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
`ifdef MEM_ACC_RANGE_CHECK_EN
      check("rng_err", {31'd0, r_err}, 32'd1);
      check("rng_ce", r_ce, 32'd0);
`else
      check("rng_err", {31'd0, r_err}, 32'd0);
      check("rng_ce", r_ce, 32'd1);
      check("rng_addr", r_addr, 32'h400);
`endif

      // Reset during the read phase of a byte store.
      do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h31;
      req_wdata = 32'h0000_0077; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("mid_rd_ce", {30'd0, ram_ce, ram_we}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ce_we", {30'd0, ram_ce, ram_we}, 32'd0);
      check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_ready", {31'd0, req_ready}, 32'd1);
      check("mid_no_resp", {31'd0, resp_valid}, 32'd0);
      check("mid_mem", mem[12], 32'hCAFE_F00D);
      do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
      check("post_rst_lb", r_rdata, 32'h0000_00FE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
